// File: rtl/rx_intf_dma_sched.sv
// rx_intf_dma_sched: queues finished-packet lengths from the RX FIFO and
// launches one DMA transfer per packet once enough words are buffered.
// Each transfer is watched for stalls (aborted after timeout_cfg idle
// cycles) and followed by a programmable idle gap.
module rx_intf_dma_sched #(
  parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
  parameter int LEN_Q_BITS             = 2,
  parameter int TIMEOUT_BITS           = 16,
  parameter int GAP_BITS               = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              pkt_end_valid,
  input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] pkt_len_word,
  input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] data_count,
  input  logic [TIMEOUT_BITS-1:0]           timeout_cfg,
  input  logic [GAP_BITS-1:0]               gap_cfg,
  input  logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  input  logic                              m_axis_tlast,
  output logic                              start_1trans,
  output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] num_dma_symbol,
  output logic                              busy,
  output logic                              abort_pulse,
  output logic                              len_q_full,
  output logic [15:0]                       drop_count,
  output logic [15:0]                       timeout_count
);

  localparam int W     = MAX_BIT_NUM_DMA_SYMBOL;
  localparam int DEPTH = 1 << LEN_Q_BITS;
  localparam logic [LEN_Q_BITS:0] DEPTH_C = (LEN_Q_BITS+1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_XFER, S_GAP} state_e;

  state_e                  state_q, state_d;
  logic [W-1:0]            len_mem_q [DEPTH];
  logic [LEN_Q_BITS-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LEN_Q_BITS:0]     cnt_q, cnt_d;
  logic [TIMEOUT_BITS-1:0] stall_q, stall_d;
  logic [GAP_BITS-1:0]     gap_q, gap_d;
  logic [W-1:0]            num_q, num_d;
  logic [15:0]             drop_q, drop_d, tout_q, tout_d;
  logic                    start_q, start_d, busy_q, busy_d;
  logic                    abort_q, abort_d, full_q, full_d;

  logic         push, pop, beat;
  logic [W-1:0] head_len;

  assign head_len = len_mem_q[rd_ptr_q];
  assign beat     = m_axis_tvalid & m_axis_tready;
  // Fullness comes from the registered count, so a same-cycle pop never frees a slot early.
  assign push     = pkt_end_valid && (cnt_q != DEPTH_C) && (pkt_len_word != '0);

  // Scheduler FSM: launch, stall watchdog, post-transfer gap, event counters.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    num_d   = num_q;
    stall_d = stall_q;
    gap_d   = gap_q;
    tout_d  = tout_q;
    abort_d = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && (cnt_q != '0) && (data_count >= head_len)) state_d = S_LOAD;
      end
      S_LOAD: begin
        num_d   = head_len - W'(1);
        state_d = S_START;
      end
      S_START: begin
        stall_d = '0;
        state_d = S_XFER;
      end
      S_XFER: begin
        // A completing tlast beat takes priority over a coincident timeout.
        if (beat && m_axis_tlast) begin
          pop     = 1'b1;
          gap_d   = '0;
          state_d = S_GAP;
        end else if ((timeout_cfg != '0) && (stall_q == timeout_cfg)) begin
          pop     = 1'b1;
          abort_d = 1'b1;
          gap_d   = '0;
          state_d = S_GAP;
          if (tout_q != 16'hFFFF) tout_d = tout_q + 16'd1;
        end else if (beat) begin
          stall_d = '0;
        end else if (stall_q != '1) begin
          stall_d = stall_q + TIMEOUT_BITS'(1);
        end
      end
      S_GAP: begin
        // gap_cfg of 0 still spends one cycle here.
        if ((GAP_BITS+1)'(gap_q) + (GAP_BITS+1)'(1) >= (GAP_BITS+1)'(gap_cfg)) state_d = S_IDLE;
        else gap_d = gap_q + GAP_BITS'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Length-queue pointers, occupancy, drop counter and registered output values.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + LEN_Q_BITS'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + LEN_Q_BITS'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + (LEN_Q_BITS+1)'(1);
    else if (!push && pop) cnt_d = cnt_q - (LEN_Q_BITS+1)'(1);
    drop_d   = drop_q;
    if (pkt_end_valid && !push && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    start_d  = (state_d == S_START);
    busy_d   = (state_d != S_IDLE);
    full_d   = (cnt_d == DEPTH_C);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      stall_q  <= '0;
      gap_q    <= '0;
      num_q    <= '0;
      drop_q   <= '0;
      tout_q   <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      abort_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      stall_q  <= stall_d;
      gap_q    <= gap_d;
      num_q    <= num_d;
      drop_q   <= drop_d;
      tout_q   <= tout_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      abort_q  <= abort_d;
      full_q   <= full_d;
    end
  end

  // Length storage; written on accepted push only.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; entries are only read while the occupancy count marks them valid.
    if (push) len_mem_q[wr_ptr_q] <= pkt_len_word;
  end

  assign start_1trans   = start_q;
  assign num_dma_symbol = num_q;
  assign busy           = busy_q;
  assign abort_pulse    = abort_q;
  assign len_q_full     = full_q;
  assign drop_count     = drop_q;
  assign timeout_count  = tout_q;

endmodule

// File: tb/tb_rx_intf_dma_sched.sv
// tb_rx_intf_dma_sched: directed scenarios plus randomized traffic, every
// cycle compared against a transaction-level reference model.
module tb_rx_intf_dma_sched;

  localparam int W     = 14;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          pkt_end_valid = 1'b0;
  logic [W-1:0]  pkt_len_word = '0;
  logic [W-1:0]  data_count = '0;
  logic [15:0]   timeout_cfg = '0;
  logic [4:0]    gap_cfg = '0;
  logic          m_axis_tvalid = 1'b0;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast = 1'b0;
  logic          start_1trans;
  logic [W-1:0]  num_dma_symbol;
  logic          busy;
  logic          abort_pulse;
  logic          len_q_full;
  logic [15:0]   drop_count;
  logic [15:0]   timeout_count;

  rx_intf_dma_sched dut (
    .clk(clk), .rst(rst), .enable(enable),
    .pkt_end_valid(pkt_end_valid), .pkt_len_word(pkt_len_word),
    .data_count(data_count), .timeout_cfg(timeout_cfg), .gap_cfg(gap_cfg),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .start_1trans(start_1trans),
    .num_dma_symbol(num_dma_symbol), .busy(busy), .abort_pulse(abort_pulse),
    .len_q_full(len_q_full), .drop_count(drop_count), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: queued lengths plus "where is the current transfer" counters.
  int lq[$];
  int m_pend;      // edges left before data phase (2 = loading, 1 = start pulse)
  bit m_xfer;      // data phase in progress
  int m_stall;     // consecutive stall cycles observed in data phase
  int m_gap;       // gap cycles still to serve
  int m_nds, m_drop, m_tout;
  bit m_abort;

  task automatic model_step();
    bit push_ok;
    bit do_end;
    m_abort = 1'b0;
    if (rst) begin
      lq.delete();
      m_pend = 0; m_xfer = 0; m_stall = 0; m_gap = 0;
      m_nds = 0; m_drop = 0; m_tout = 0;
      return;
    end
    push_ok = pkt_end_valid && (pkt_len_word != 0) && (lq.size() < DEPTH);
    if (pkt_end_valid && !push_ok && m_drop < 65535) m_drop++;
    do_end = 1'b0;
    if (m_xfer) begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) do_end = 1'b1;
      else if (timeout_cfg != 0 && m_stall == int'(timeout_cfg)) begin
        do_end = 1'b1;
        m_abort = 1'b1;
        if (m_tout < 65535) m_tout++;
      end else if (m_axis_tvalid && m_axis_tready) m_stall = 0;
      else m_stall++;
      if (do_end) begin
        void'(lq.pop_front());
        m_xfer = 1'b0;
        m_gap = (gap_cfg == 0) ? 1 : int'(gap_cfg);
      end
    end else if (m_pend > 0) begin
      if (m_pend == 2) m_nds = lq[0] - 1;
      m_pend--;
      if (m_pend == 0) begin
        m_xfer = 1'b1;
        m_stall = 0;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (enable && lq.size() > 0 && int'(data_count) >= lq[0]) begin
      m_pend = 2;
    end
    if (push_ok) lq.push_back(int'(pkt_len_word));
  endtask

  task automatic compare();
    check("start_1trans", 32'(start_1trans), 32'(m_pend == 1));
    check("busy", 32'(busy), 32'(m_pend > 0 || m_xfer || m_gap > 0));
    check("abort_pulse", 32'(abort_pulse), 32'(m_abort));
    check("len_q_full", 32'(len_q_full), 32'(lq.size() == DEPTH));
    check("num_dma_symbol", 32'(num_dma_symbol), 32'(m_nds));
    check("drop_count", 32'(drop_count), 32'(m_drop));
    check("timeout_count", 32'(timeout_count), 32'(m_tout));
  endtask

  // One clock: model follows the edge, outputs sampled on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pkt_end_valid = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    m_axis_tlast = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic push_len(input int len);
    pkt_end_valid = 1'b1;
    pkt_len_word = W'(len);
    cycle();
    pkt_end_valid = 1'b0;
  endtask

  int k_start;
  int n_abort;

  initial begin
    @(negedge clk);
    do_reset();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_num", 32'(num_dma_symbol), 32'd0);
    check("reset_full", 32'(len_q_full), 32'd0);

    // Len 8 transfer, start pulse on third cycle after push, 8 beats then gap.
    enable = 1'b1; data_count = W'(8); timeout_cfg = '0; gap_cfg = '0;
    push_len(8);
    k_start = 0;
    for (int k = 2; k <= 10; k++) begin
      cycle();
      if (start_1trans && k_start == 0) k_start = k;
    end
    check("start_cycle", 32'(k_start), 32'd3);
    check("num_dma_len8", 32'(num_dma_symbol), 32'd7);
    m_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
    for (int b = 1; b <= 8; b++) begin
      m_axis_tlast = (b == 8);
      cycle();
    end
    m_axis_tvalid = 1'b0; m_axis_tlast = 1'b0;
    check("gap_busy", 32'(busy), 32'd1);
    cycle();
    check("idle_after_gap", 32'(busy), 32'd0);

    // Insufficient fill level holds the scheduler in idle.
    do_reset();
    data_count = W'(10);
    push_len(16);
    repeat (4) cycle();
    check("hold_idle", 32'(busy), 32'd0);
    data_count = W'(16);
    cycle();
    check("load_after_fill", 32'(busy), 32'd1);

    // Queue overflow with enable low.
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) push_len(3);
    check("q_full", 32'(len_q_full), 32'd1);
    check("drop_one", 32'(drop_count), 32'd1);

    // Stall timeout aborts after 20 idle cycles.
    do_reset();
    enable = 1'b1; data_count = W'(100); timeout_cfg = 16'd20;
    push_len(2);
    n_abort = 0;
    repeat (40) begin
      cycle();
      if (abort_pulse) n_abort++;
    end
    check("abort_once", 32'(n_abort), 32'd1);
    check("tout_count", 32'(timeout_count), 32'd1);

    // tlast on the timeout cycle completes normally.
    do_reset();
    push_len(2);
    for (int k = 0; k < 10 && !start_1trans; k++) cycle();
    check("start_seen", 32'(start_1trans), 32'd1);
    repeat (21) cycle();
    m_axis_tvalid = 1'b1; m_axis_tready = 1'b1; m_axis_tlast = 1'b1;
    cycle();
    m_axis_tvalid = 1'b0; m_axis_tready = 1'b0; m_axis_tlast = 1'b0;
    n_abort = 0;
    repeat (3) begin
      if (abort_pulse) n_abort++;
      cycle();
    end
    check("tlast_wins_abort", 32'(n_abort), 32'd0);
    check("tlast_wins_count", 32'(timeout_count), 32'd0);

    // Randomized traffic, configuration fixed per segment.
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      case (seg % 3)
        0: timeout_cfg = 16'd0;
        1: timeout_cfg = 16'd5;
        default: timeout_cfg = 16'd20;
      endcase
      gap_cfg = 5'($urandom_range(0, 6));
      for (int c = 0; c < 2500; c++) begin
        rst = ($urandom_range(0, 599) == 0);
        enable = ($urandom_range(0, 9) != 0);
        pkt_end_valid = ($urandom_range(0, 4) == 0);
        pkt_len_word = W'($urandom_range(0, 24));
        data_count = W'($urandom_range(0, 31));
        m_axis_tvalid = (seg < 3) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
        m_axis_tready = ($urandom_range(0, 3) != 0);
        m_axis_tlast = ($urandom_range(0, 5) == 0);
        cycle();
      end
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
